// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//   Load/store unit for the pipeline MEM stage. Turns one MEM-stage load or
//   store into a single-beat 64-bit AXI transaction, freezes the pipeline
//   with `stall` while the bus is busy and reports completion with a
//   one-cycle `resp_valid` pulse carrying extended load data and an error bit.
//
//   Optional build macro:
//     LSU_MISALIGN_TRAP_EN - when defined, an access whose address is not
//       aligned to its size skips the bus and completes with resp_err=1 and
//       resp_data=0. When undefined, the low address bits are masked down to
//       size alignment and the access proceeds normally.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   req_*                MEM-stage request (valid, store/load, address, store
//                        data LSB-aligned, size 0=B..3=D, zero-extend)
//   stall                freeze MEM and upstream stages
//   resp_valid/data/err  one-cycle completion, extended load data, error
//   m_axi_ar* / m_axi_r* AXI read address / read data channels (master)
//   m_axi_aw* / m_axi_w* AXI write address / write data channels (master)
//   m_axi_b*             AXI write response channel (master)
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64  // only 64 is supported
) (
  input  logic                    clk,
  input  logic                    reset,
  // MEM-stage request
  input  logic                    req_valid,
  input  logic                    req_is_store,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  // Response to the pipeline
  output logic                    stall,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  // AXI read address channel
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // AXI read data channel
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  // AXI write address channel
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // AXI write response channel
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t                    state;

  // Request fields latched at accept
  logic [ADDR_WIDTH-1:0]     addr_q;      // 8-byte aligned bus address
  logic [2:0]                off_q;       // size-aligned byte offset in the beat
  logic [1:0]                size_q;
  logic                      unsigned_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;

  // Accept-cycle decode
  logic [2:0]                size_mask;   // low address bits that must be 0 for this size
  logic [DATA_WIDTH/8-1:0]   size_bytes;  // byte-enable pattern before shifting
  logic [2:0]                off_in;
  logic                      trap_now;

  logic [DATA_WIDTH-1:0]     rshift;
  logic [DATA_WIDTH-1:0]     load_ext;

  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned; a missing branch would otherwise infer a latch.
  always_comb begin
    size_mask  = 3'b111;
    size_bytes = 8'hFF;
    case (req_size)
      2'd0:    begin size_mask = 3'b000; size_bytes = 8'h01; end
      2'd1:    begin size_mask = 3'b001; size_bytes = 8'h03; end
      2'd2:    begin size_mask = 3'b011; size_bytes = 8'h0F; end
      default: begin size_mask = 3'b111; size_bytes = 8'hFF; end
    endcase
  end

  // Misaligned low bits are simply dropped unless the trap build is selected.
  assign off_in = req_addr[2:0] & ~size_mask;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_now = |(req_addr[2:0] & size_mask);
`else
  assign trap_now = 1'b0;
`endif

  // Load extraction: move the addressed lane down to bit 0, then extend.
  assign rshift = m_axi_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = rshift;
    case (size_q)
      2'd0: load_ext = unsigned_q ? {56'd0, rshift[7:0]}
                                  : {{56{rshift[7]}}, rshift[7:0]};
      2'd1: load_ext = unsigned_q ? {48'd0, rshift[15:0]}
                                  : {{48{rshift[15]}}, rshift[15:0]};
      2'd2: load_ext = unsigned_q ? {32'd0, rshift[31:0]}
                                  : {{32{rshift[31]}}, rshift[31:0]};
      default: load_ext = rshift;  // doubleword ignores req_unsigned
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      addr_q        <= '0;
      off_q         <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      resp_valid <= 1'b0;  // pulse: only the transition into DONE raises it
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
            off_q      <= off_in;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata << {off_in, 3'b000};
            wstrb_q    <= size_bytes << off_in;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            if (trap_now) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else if (req_is_store) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            resp_data  <= load_ext;
            resp_err   <= (m_axi_rresp != 2'b00);
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        WR_REQ: begin
          // AW and W complete independently; leave once neither is pending.
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready))
            state <= WR_RESP;
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            resp_err   <= (m_axi_bresp != 2'b00);
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = (state == IDLE) ? req_valid : (state != DONE);

  // IDLE keeps both response readies high so beats of an abandoned
  // transaction are drained instead of blocking the slave.
  assign m_axi_rready = (state == IDLE) || (state == RD_DATA);
  assign m_axi_bready = (state == IDLE) || (state == WR_RESP);

  // Fixed single-beat, 8-byte, incrementing burst attributes
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;

  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;

  // Only one transaction is ever outstanding, so IDs and rlast carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_rid, m_axi_rlast, m_axi_bid};

endmodule
